// File: rtl/vector_add_pkg.sv
// Shared sizing and FSM state types for the vector-add stream driver and its result unpacker.
package vector_add_pkg;

   localparam int N_ELEM     = 10;
   localparam int ELEM_IN_W  = 15;
   localparam int ELEM_OUT_W = 16;
   localparam int VEC_IN_W   = 2 * N_ELEM * ELEM_IN_W;
   localparam int VEC_OUT_W  = N_ELEM * ELEM_OUT_W;
   localparam int K_W        = $clog2(2 * N_ELEM);
   localparam int J_W        = $clog2(N_ELEM);

   localparam logic [K_W-1:0] K_LAST = K_W'(2 * N_ELEM - 1);
   localparam logic [J_W-1:0] J_LAST = J_W'(N_ELEM - 1);

   typedef enum logic {
      PACK_COLLECT = 1'b0,
      PACK_SEND    = 1'b1
   } pack_state_e;

   typedef enum logic {
      UNPK_IDLE = 1'b0,
      UNPK_EMIT = 1'b1
   } unpack_state_e;

endpackage

// File: rtl/vector_result_unpacker.sv
// Unpacks one wide result word into a stream of N_ELEM elements, S0 first.
// VEC_DRV_TLAST_EN adds the registered m_elem_last flag on the final element.
module vector_result_unpacker
   import vector_add_pkg::*;
(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [VEC_OUT_W-1:0]  s_res_data,
   input  logic                  s_res_valid,
   output logic                  s_res_ready,
   output logic [ELEM_OUT_W-1:0] m_elem_data,
   output logic                  m_elem_valid,
   input  logic                  m_elem_ready
`ifdef VEC_DRV_TLAST_EN
   ,
   output logic                  m_elem_last
`endif
);

   unpack_state_e        state_q, state_d;
   logic [J_W-1:0]       j_q, j_d;
   logic [VEC_OUT_W-1:0] res_q, res_d;
   logic                 ready_q, ready_d;
   logic                 valid_q, valid_d;

   // The current element always sits in the top slice; each handshake shifts the next one up.
   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      res_d   = res_q;
      ready_d = ready_q;
      valid_d = valid_q;
      case (state_q)
         UNPK_IDLE: begin
            if (s_res_valid && ready_q) begin
               res_d   = s_res_data;
               ready_d = 1'b0;
               valid_d = 1'b1;
               j_d     = '0;
               state_d = UNPK_EMIT;
            end else begin
               ready_d = 1'b1;
            end
         end
         UNPK_EMIT: begin
            if (m_elem_ready && valid_q) begin
               if (j_q == J_LAST) begin
                  valid_d = 1'b0;
                  ready_d = 1'b1;
                  j_d     = '0;
                  state_d = UNPK_IDLE;
               end else begin
                  j_d   = j_q + J_W'(1);
                  res_d = {res_q[VEC_OUT_W-ELEM_OUT_W-1:0], {ELEM_OUT_W{1'b0}}};
               end
            end else begin
               valid_d = valid_q;
            end
         end
         default: begin
            state_d = UNPK_IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
            j_d     = '0;
         end
      endcase
   end

   // Unpack state register with synchronous active-low reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= UNPK_IDLE;
         j_q     <= '0;
         res_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         res_q   <= res_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

`ifdef VEC_DRV_TLAST_EN
   logic last_q;

   // Flag registered from next-state so it tracks valid and index exactly.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         last_q <= 1'b0;
      end else begin
         last_q <= valid_d && (j_d == J_LAST);
      end
   end

   assign m_elem_last = last_q;
`endif

   assign s_res_ready  = ready_q;
   assign m_elem_valid = valid_q;
   assign m_elem_data  = res_q[VEC_OUT_W-1 -: ELEM_OUT_W];

endmodule

// File: rtl/vector_add_stream_driver.sv
// Packs 2*N_ELEM narrow operands into one A|B word and unpacks the wide sum word into elements.
// Optional macro VEC_DRV_TLAST_EN exposes m_elem_last on the result stream.
module vector_add_stream_driver
   import vector_add_pkg::*;
(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ELEM_IN_W-1:0]  s_elem_data,
   input  logic                  s_elem_valid,
   output logic                  s_elem_ready,
   output logic [VEC_IN_W-1:0]   m_vec_data,
   output logic                  m_vec_valid,
   input  logic                  m_vec_ready,
   input  logic [VEC_OUT_W-1:0]  s_res_data,
   input  logic                  s_res_valid,
   output logic                  s_res_ready,
   output logic [ELEM_OUT_W-1:0] m_elem_data,
   output logic                  m_elem_valid,
   input  logic                  m_elem_ready
`ifdef VEC_DRV_TLAST_EN
   ,
   output logic                  m_elem_last
`endif
);

   pack_state_e         state_q, state_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [VEC_IN_W-1:0] vec_q, vec_d;
   logic                ready_q, ready_d;
   logic                valid_q, valid_d;

   // Element k lands at the k-th slice from the top, so A0 ends up in the MSBs.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      vec_d   = vec_q;
      ready_d = ready_q;
      valid_d = valid_q;
      case (state_q)
         PACK_COLLECT: begin
            if (s_elem_valid && ready_q) begin
               vec_d[VEC_IN_W-1-int'(k_q)*ELEM_IN_W -: ELEM_IN_W] = s_elem_data;
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  ready_d = 1'b0;
                  valid_d = 1'b1;
                  state_d = PACK_SEND;
               end else begin
                  k_d = k_q + K_W'(1);
               end
            end else begin
               k_d = k_q;
            end
         end
         PACK_SEND: begin
            if (m_vec_ready) begin
               valid_d = 1'b0;
               ready_d = 1'b1;
               state_d = PACK_COLLECT;
            end else begin
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = PACK_COLLECT;
            k_d     = '0;
            ready_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   // Pack state register with synchronous active-low reset; drops any partial vector.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= PACK_COLLECT;
         k_q     <= '0;
         vec_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         vec_q   <= vec_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign s_elem_ready = ready_q;
   assign m_vec_valid  = valid_q;
   assign m_vec_data   = vec_q;

   vector_result_unpacker u_unpacker (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .s_res_data   (s_res_data),
      .s_res_valid  (s_res_valid),
      .s_res_ready  (s_res_ready),
      .m_elem_data  (m_elem_data),
      .m_elem_valid (m_elem_valid),
      .m_elem_ready (m_elem_ready)
`ifdef VEC_DRV_TLAST_EN
      ,
      .m_elem_last  (m_elem_last)
`endif
   );

endmodule

// File: tb/tb_vector_add_stream_driver.sv
// Directed bench for vector_add_stream_driver: pack, stall, unpack, backpressure, reset, concurrency.
module tb_vector_add_stream_driver;
   import vector_add_pkg::*;

   logic                  aclk = 1'b0;
   logic                  aresetn = 1'b0;
   logic [ELEM_IN_W-1:0]  s_elem_data = '0;
   logic                  s_elem_valid = 1'b0;
   logic                  s_elem_ready;
   logic [VEC_IN_W-1:0]   m_vec_data;
   logic                  m_vec_valid;
   logic                  m_vec_ready = 1'b1;
   logic [VEC_OUT_W-1:0]  s_res_data = '0;
   logic                  s_res_valid = 1'b0;
   logic                  s_res_ready;
   logic [ELEM_OUT_W-1:0] m_elem_data;
   logic                  m_elem_valid;
   logic                  m_elem_ready = 1'b1;
`ifdef VEC_DRV_TLAST_EN
   logic                  m_elem_last;
`endif

   int n_checks = 0;
   int n_errors = 0;

   typedef logic [VEC_IN_W-1:0] cval_t;

   vector_add_stream_driver dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .s_elem_data  (s_elem_data),
      .s_elem_valid (s_elem_valid),
      .s_elem_ready (s_elem_ready),
      .m_vec_data   (m_vec_data),
      .m_vec_valid  (m_vec_valid),
      .m_vec_ready  (m_vec_ready),
      .s_res_data   (s_res_data),
      .s_res_valid  (s_res_valid),
      .s_res_ready  (s_res_ready),
      .m_elem_data  (m_elem_data),
      .m_elem_valid (m_elem_valid),
      .m_elem_ready (m_elem_ready)
`ifdef VEC_DRV_TLAST_EN
      ,
      .m_elem_last  (m_elem_last)
`endif
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input cval_t obs, input cval_t exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected packed word for 20 consecutive values starting at base, first value in the MSBs.
   function automatic logic [VEC_IN_W-1:0] pack_exp(input int base);
      logic [VEC_IN_W-1:0] w;
      w = '0;
      for (int i = 0; i < 2 * N_ELEM; i++) begin
         w[VEC_IN_W-1-i*ELEM_IN_W -: ELEM_IN_W] = ELEM_IN_W'(base + i);
      end
      return w;
   endfunction

   function automatic logic [VEC_OUT_W-1:0] res_word(input int base);
      logic [VEC_OUT_W-1:0] w;
      w = '0;
      for (int i = 0; i < N_ELEM; i++) begin
         w[VEC_OUT_W-1-i*ELEM_OUT_W -: ELEM_OUT_W] = ELEM_OUT_W'(base + i);
      end
      return w;
   endfunction

   // Called at a negedge; returns at the negedge after the element's handshake.
   task automatic put_elem(input int v);
      int cnt;
      cnt = 0;
      s_elem_data  = ELEM_IN_W'(v);
      s_elem_valid = 1'b1;
      while (!s_elem_ready && cnt < 50) begin
         @(negedge aclk);
         cnt++;
      end
      if (cnt >= 50) check("elem_ready_timeout", cval_t'(cnt), cval_t'(0));
      @(posedge aclk);
      @(negedge aclk);
      s_elem_valid = 1'b0;
   endtask

   task automatic send_res(input logic [VEC_OUT_W-1:0] w);
      int cnt;
      cnt = 0;
      s_res_data  = w;
      s_res_valid = 1'b1;
      while (!s_res_ready && cnt < 50) begin
         @(negedge aclk);
         cnt++;
      end
      if (cnt >= 50) check("res_ready_timeout", cval_t'(cnt), cval_t'(0));
      @(posedge aclk);
      @(negedge aclk);
      s_res_valid = 1'b0;
      check("res_elem_valid_start", cval_t'(m_elem_valid), cval_t'(1'b1));
      check("res_ready_busy", cval_t'(s_res_ready), cval_t'(1'b0));
   endtask

   task automatic drain(input bit toggle, input int base);
      int j;
      int cyc;
      j   = 0;
      cyc = 0;
      while (j < N_ELEM && cyc < 200) begin
         m_elem_ready = toggle ? cyc[0] : 1'b1;
         if (m_elem_valid) begin
            check("elem_data", cval_t'(m_elem_data), cval_t'(base + j));
`ifdef VEC_DRV_TLAST_EN
            check("elem_last", cval_t'(m_elem_last), cval_t'(j == N_ELEM - 1));
`endif
            if (m_elem_ready) j++;
         end
         @(posedge aclk);
         @(negedge aclk);
         cyc++;
      end
      m_elem_ready = 1'b1;
      check("elem_count", cval_t'(j), cval_t'(N_ELEM));
      check("elem_cycles", cval_t'(cyc), cval_t'(toggle ? 2 * N_ELEM : N_ELEM));
      check("elem_valid_end", cval_t'(m_elem_valid), cval_t'(1'b0));
      check("res_ready_end", cval_t'(s_res_ready), cval_t'(1'b1));
`ifdef VEC_DRV_TLAST_EN
      check("elem_last_end", cval_t'(m_elem_last), cval_t'(1'b0));
`endif
   endtask

   initial begin
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_s_elem_ready", cval_t'(s_elem_ready), cval_t'(1'b1));
      check("rst_s_res_ready", cval_t'(s_res_ready), cval_t'(1'b1));
      check("rst_m_vec_valid", cval_t'(m_vec_valid), cval_t'(1'b0));
      check("rst_m_elem_valid", cval_t'(m_elem_valid), cval_t'(1'b0));
      check("rst_m_vec_data", cval_t'(m_vec_data), cval_t'(0));
      check("rst_m_elem_data", cval_t'(m_elem_data), cval_t'(0));
`ifdef VEC_DRV_TLAST_EN
      check("rst_m_elem_last", cval_t'(m_elem_last), cval_t'(1'b0));
`endif
      aresetn = 1'b1;
      @(negedge aclk);

      // Single-beat pack with the wrapper always ready.
      for (int v = 1; v <= 2 * N_ELEM; v++) put_elem(v);
      check("pack1_valid", cval_t'(m_vec_valid), cval_t'(1'b1));
      check("pack1_elem_ready", cval_t'(s_elem_ready), cval_t'(1'b0));
      check("pack1_data", m_vec_data, pack_exp(1));
      @(posedge aclk);
      @(negedge aclk);
      check("pack1_single_beat", cval_t'(m_vec_valid), cval_t'(1'b0));
      check("pack1_elem_ready_back", cval_t'(s_elem_ready), cval_t'(1'b1));

      // Wrapper stalls for 5 cycles while the next element is already offered.
      m_vec_ready = 1'b0;
      for (int v = 21; v <= 40; v++) put_elem(v);
      check("pack2_data", m_vec_data, pack_exp(21));
      s_elem_data  = ELEM_IN_W'(41);
      s_elem_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge aclk);
         @(negedge aclk);
         check("stall_valid", cval_t'(m_vec_valid), cval_t'(1'b1));
         check("stall_data", m_vec_data, pack_exp(21));
         check("stall_elem_ready", cval_t'(s_elem_ready), cval_t'(1'b0));
      end
      m_vec_ready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check("stall_release_valid", cval_t'(m_vec_valid), cval_t'(1'b0));
      check("stall_release_ready", cval_t'(s_elem_ready), cval_t'(1'b1));
      for (int v = 41; v <= 60; v++) put_elem(v);
      check("pack3_data", m_vec_data, pack_exp(41));
      @(posedge aclk);
      @(negedge aclk);

      // Unpack with and without downstream backpressure.
      send_res(res_word(100));
      drain(1'b0, 100);
      send_res(res_word(100));
      drain(1'b1, 100);

      // Reset mid-vector discards the partial operands.
      for (int v = 70; v < 77; v++) put_elem(v);
      aresetn = 1'b0;
      @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      check("midrst_vec_valid", cval_t'(m_vec_valid), cval_t'(1'b0));
      check("midrst_elem_ready", cval_t'(s_elem_ready), cval_t'(1'b1));
      check("midrst_vec_data", cval_t'(m_vec_data), cval_t'(0));
      for (int v = 50; v <= 69; v++) put_elem(v);
      check("midrst_pack_data", m_vec_data, pack_exp(50));
      check("midrst_pack_valid", cval_t'(m_vec_valid), cval_t'(1'b1));
      @(posedge aclk);
      @(negedge aclk);

      // Pack and unpack traffic at the same time.
      fork
         begin
            for (int v = 200; v < 220; v++) put_elem(v);
            check("conc_pack_valid", cval_t'(m_vec_valid), cval_t'(1'b1));
            check("conc_pack_data", m_vec_data, pack_exp(200));
         end
         begin
            send_res(res_word(1000));
            drain(1'b1, 1000);
         end
      join
      @(posedge aclk);
      @(negedge aclk);
      check("conc_vec_done", cval_t'(m_vec_valid), cval_t'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
